// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared state encoding, width derivation and score reduction for the dense argmax engine
package nn_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_LOAD_X  = 3'd3;
  localparam logic [2:0] S_COMPUTE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int acc_width(input int n_in, input int data_w);
    return 2 * data_w + clog2(n_in) + 1;
  endfunction

  // Clamps to the signed data_w range when sat is set; otherwise the caller truncates (wraps).
  function automatic logic signed [63:0] fit_score(input logic signed [63:0] v,
                                                   input int data_w, input bit sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (sat && (v > hi)) return hi;
    if (sat && (v < lo)) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dense_argmax_engine_if.sv
// rtl/dense_argmax_engine_if.sv - valid/ready word stream carrying weights, biases and features
interface dense_argmax_engine_if #(
  parameter int DATA_W = 16
) ();
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/dense_mac.sv
// rtl/dense_mac.sv - signed MAC with bias load on the first term; SATURATE_EN selects clamped vs wrapped score
module dense_mac import nn_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 35
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_i,
  input  logic                     clear_i,
  input  logic signed [DATA_W-1:0] w_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] score_o
);
`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [63:0]         acc_ext;

  assign prod     = w_i * x_i;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W){b_i[DATA_W-1]}}, b_i} <<< FRAC_W;
  assign acc_d    = clear_i ? (bias_ext + prod_ext) : (acc_q + prod_ext);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    acc_q <= '0;
    else if (en_i) acc_q <= acc_d;
  end

  // Score is derived from the registered sum, so it is valid the cycle after a neuron's last MAC.
  assign acc_ext = {{(64-ACC_W){acc_q[ACC_W-1]}}, acc_q};
  assign score_o = DATA_W'(fit_score(acc_ext >>> FRAC_W, DATA_W, SAT));

endmodule

// File: rtl/dense_argmax_engine.sv
// rtl/dense_argmax_engine.sv - fully connected layer plus argmax; weights retained across inferences (SATURATE_EN in dense_mac)
module dense_argmax_engine import nn_pkg::*; #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_cfg,
  input  logic                      start_inf,
  dense_argmax_engine_if.slave      s,
  output logic                      busy,
  output logic                      cfg_loaded,
  output logic                      result_valid,
  output logic [clog2(N_OUT)-1:0]   max_idx,
  output logic [N_OUT-1:0]          max_onehot,
  output logic signed [DATA_W-1:0]  max_score,
  output logic                      err_nocfg
);
  localparam int IW    = (clog2(N_IN) < 1) ? 1 : clog2(N_IN);
  localparam int OW    = clog2(N_OUT);
  localparam int ACC_W = acc_width(N_IN, DATA_W);

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [OW-1:0] o_q, o_d;
  logic          fin_q, fin_d, cfg_q, cfg_d, rv_q, rv_d, err_q, err_d;
  logic          upd_q;
  logic [OW-1:0] upd_o_q;
  logic [OW-1:0] idx_q, idx_d;
  logic signed [DATA_W-1:0] max_q, max_d, score;
  logic          hs, i_last, o_last, mac_en;

  logic signed [DATA_W-1:0] w_q [N_OUT][N_IN];
  logic signed [DATA_W-1:0] b_q [N_OUT];
  logic signed [DATA_W-1:0] x_q [N_IN];

  assign s.in_ready = (state_q == S_LOAD_W) || (state_q == S_LOAD_B) || (state_q == S_LOAD_X);
  assign hs         = s.in_valid && s.in_ready;
  assign i_last     = (i_q == IW'(N_IN - 1));
  assign o_last     = (o_q == OW'(N_OUT - 1));

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    o_d     = o_q;
    fin_d   = fin_q;
    cfg_d   = cfg_q;
    rv_d    = rv_q;
    err_d   = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_cfg) begin
          state_d = S_LOAD_W;
          cfg_d   = 1'b0;
          rv_d    = 1'b0;
          i_d     = '0;
          o_d     = '0;
        end else if (start_inf) begin
          if (cfg_q) begin
            state_d = S_LOAD_X;
            rv_d    = 1'b0;
            i_d     = '0;
            o_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD_W: if (hs) begin
        i_d = i_last ? '0 : i_q + 1'b1;
        if (i_last) begin
          o_d = o_last ? '0 : o_q + 1'b1;
          if (o_last) state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: if (hs) begin
        o_d = o_last ? '0 : o_q + 1'b1;
        if (o_last) begin
          cfg_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_LOAD_X: if (hs) begin
        i_d = i_last ? '0 : i_q + 1'b1;
        if (i_last) begin
          fin_d   = 1'b0;
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        // One extra cycle after the last MAC lets the final neuron's score reach the argmax.
        if (fin_q) begin
          fin_d   = 1'b0;
          rv_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          mac_en = 1'b1;
          i_d    = i_last ? '0 : i_q + 1'b1;
          if (i_last) begin
            o_d = o_last ? '0 : o_q + 1'b1;
            if (o_last) fin_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  dense_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_mac (
    .clk     (clk),
    .reset   (reset),
    .en_i    (mac_en),
    .clear_i (i_q == '0),
    .w_i     (w_q[o_q][i_q]),
    .x_i     (x_q[i_q]),
    .b_i     (b_q[o_q]),
    .score_o (score)
  );

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    idx_d = idx_q;
    max_d = max_q;
    if (upd_q && ((upd_o_q == '0) || (score > max_q))) begin
      idx_d = upd_o_q;
      max_d = score;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      o_q     <= '0;
      fin_q   <= 1'b0;
      cfg_q   <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      upd_q   <= 1'b0;
      upd_o_q <= '0;
      idx_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      o_q     <= o_d;
      fin_q   <= fin_d;
      cfg_q   <= cfg_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      upd_q   <= mac_en && i_last;
      upd_o_q <= o_q;
      idx_q   <= idx_d;
      max_q   <= max_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      case (state_q)
        S_LOAD_W: w_q[o_q][i_q] <= s.in_data;
        S_LOAD_B: b_q[o_q]      <= s.in_data;
        S_LOAD_X: x_q[i_q]      <= s.in_data;
        default:  ;
      endcase
    end
  end

  always_comb begin
    max_onehot = '0;
    for (int k = 0; k < N_OUT; k++) max_onehot[k] = rv_q && (idx_q == OW'(k));
  end

  assign busy         = !((state_q == S_IDLE) || (state_q == S_DONE));
  assign cfg_loaded   = cfg_q;
  assign result_valid = rv_q;
  assign max_idx      = idx_q;
  assign max_score    = max_q;
  assign err_nocfg    = err_q;

endmodule

// File: tb/tb_dense_argmax_engine.sv
// tb/tb_dense_argmax_engine.sv - directed and randomized checks of dense_argmax_engine against an arithmetic reference
module tb_dense_argmax_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_cfg = 1'b0;
  logic start_inf = 1'b0;
  logic busy, cfg_loaded, result_valid, err_nocfg;
  logic [0:0] max_idx;
  logic [1:0] max_onehot;
  logic signed [15:0] max_score;

  int tests = 0;
  int fails = 0;

  logic signed [15:0] tw [6];
  logic signed [15:0] tbias [2];
  logic signed [15:0] tx [3];

  dense_argmax_engine_if #(.DATA_W(16)) bus ();

  dense_argmax_engine #(.N_IN(3), .N_OUT(2), .DATA_W(16), .FRAC_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_cfg    (start_cfg),
    .start_inf    (start_inf),
    .s            (bus),
    .busy         (busy),
    .cfg_loaded   (cfg_loaded),
    .result_valid (result_valid),
    .max_idx      (max_idx),
    .max_onehot   (max_onehot),
    .max_score    (max_score),
    .err_nocfg    (err_nocfg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit c, input bit i);
    start_cfg = c;
    start_inf = i;
    tick();
    start_cfg = 1'b0;
    start_inf = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] v, input bit gaps);
    int  n;
    logic r;
    if (gaps) repeat ($urandom_range(0, 3)) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    n = 0;
    do begin
      r = bus.in_ready;
      tick();
      n++;
    end while (!r && n < 50);
    bus.in_valid = 1'b0;
    chk("handshake", {15'd0, r}, 16'd1);
  endtask

  // Reference: score_o = floor((b*2^8 + sum w*x) / 2^8), reduced to 16 bits, then first strict maximum.
  task automatic model(output logic [15:0] e_idx, output logic [15:0] e_sc);
    longint acc, sc;
    logic signed [15:0] s16, best;
    best  = '0;
    e_idx = '0;
    for (int o = 0; o < 2; o++) begin
      acc = longint'(tbias[o]) * 256;
      for (int i = 0; i < 3; i++) acc += longint'(tw[o*3+i]) * longint'(tx[i]);
      sc = acc >>> 8;
`ifdef SATURATE_EN
      if (sc > 32767)  sc = 32767;
      if (sc < -32768) sc = -32768;
`endif
      s16 = sc[15:0];
      if (o == 0 || s16 > best) begin
        best  = s16;
        e_idx = 16'(o);
      end
    end
    e_sc = best;
  endtask

  task automatic do_cfg(input bit gaps, input bit both);
    pulse(1'b1, both);
    if (both) chk("both_start", {12'd0, busy, bus.in_ready, err_nocfg, cfg_loaded}, 16'b1100);
    for (int k = 0; k < 6; k++) send_word(tw[k], gaps);
    for (int k = 0; k < 2; k++) send_word(tbias[k], gaps);
    chk("cfg_loaded", {15'd0, cfg_loaded}, 16'd1);
  endtask

  task automatic do_inf(input string tag, input bit gaps, input bit poke);
    int lat;
    logic [15:0] ei, es;
    pulse(1'b0, 1'b1);
    if (poke) begin
      pulse(1'b1, 1'b0);
      chk({tag, "_ignored"}, {14'd0, cfg_loaded, bus.in_ready}, 16'b11);
    end
    for (int k = 0; k < 3; k++) send_word(tx[k], gaps);
    lat = 0;
    while (!result_valid && lat < 100) begin
      tick();
      lat++;
    end
    model(ei, es);
    chk({tag, "_lat"}, 16'(lat), 16'd7);
    chk({tag, "_idx"}, {15'd0, max_idx}, ei);
    chk({tag, "_score"}, max_score, es);
    chk({tag, "_onehot"}, {14'd0, max_onehot}, 16'd1 << ei);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #2 reset = 1'b0;
    repeat (2) tick();
    chk("rst_flags", {9'd0, busy, cfg_loaded, result_valid, err_nocfg, bus.in_ready, max_onehot}, 16'd0);
    chk("rst_score", max_score, 16'd0);
    chk("rst_idx", {15'd0, max_idx}, 16'd0);
    reset = 1'b1;
    tick();

    pulse(1'b0, 1'b1);
    chk("nocfg_err", {15'd0, err_nocfg}, 16'd1);
    chk("nocfg_idle", {14'd0, busy, bus.in_ready}, 16'd0);
    tick();
    chk("nocfg_pulse", {15'd0, err_nocfg}, 16'd0);

    tw    = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000};
    tbias = '{16'h0000, 16'h0000};
    do_cfg(1'b0, 1'b0);
    tx = '{16'h0200, 16'h0300, 16'h0000};
    do_inf("t1", 1'b0, 1'b0);
    chk("t1_const", {max_onehot, 13'd0, max_idx}, 16'h8001);
    chk("t1_score_const", max_score, 16'h0300);

    tx = '{16'h0300, 16'h0300, 16'h0000};
    do_inf("tie", 1'b0, 1'b0);
    chk("tie_const", {15'd0, max_idx}, 16'd0);

    tx = '{16'h0000, 16'h0100, 16'h0000};
    do_inf("reuse", 1'b0, 1'b1);
    chk("reuse_const", max_score, 16'h0100);

    tw    = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    tbias = '{16'hFF00, 16'hFE00};
    do_cfg(1'b0, 1'b0);
    tx = '{16'h0, 16'h0, 16'h0};
    do_inf("bias", 1'b0, 1'b0);
    chk("bias_const", max_score, 16'hFF00);

    tw    = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    tbias = '{16'h0, 16'h0};
    do_cfg(1'b0, 1'b1);
    tx = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    do_inf("big", 1'b0, 1'b0);
`ifdef SATURATE_EN
    chk("big_const", max_score, 16'h7FFF);
`else
    chk("big_const", max_score, 16'hFD00);
`endif

    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 6; k++)
        tw[k] = (it % 2 == 1) ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
      for (int k = 0; k < 2; k++)
        tbias[k] = (it % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
      for (int k = 0; k < 3; k++)
        tx[k] = (it % 2 == 1) ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
      do_cfg(1'b1, it == 3);
      do_inf("rnd_nogap", 1'b0, 1'b0);
      do_inf("rnd_gap", 1'b1, it[0]);
    end

    pulse(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) send_word(tx[k], 1'b0);
    tick();
    tick();
    chk("pre_rst_busy", {15'd0, busy}, 16'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_flags", {9'd0, busy, cfg_loaded, result_valid, err_nocfg, bus.in_ready, max_onehot}, 16'd0);
    chk("async_score", max_score, 16'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    pulse(1'b0, 1'b1);
    chk("post_rst_err", {14'd0, err_nocfg, busy}, 16'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dense_argmax_engine.md
Name: dense_argmax_engine

Overview:
- Parametrised successor of the single-layer float classifier: one fully connected layer (N_IN inputs, N_OUT outputs) in signed fixed point, followed by an argmax.
- Weights and biases are loaded once through a valid/ready stream and retained; each feature vector streamed afterwards produces class scores and a winning index.
- Sits between the feature-extraction front end and the face-ID decision logic.

Parameters:
N_IN, 3, features per vector (>=1)
N_OUT, 2, classes/neurons (>=2)
DATA_W, 16, signed width of features, weights, biases, scores
FRAC_W, 8, fractional bits (Q(DATA_W-FRAC_W).FRAC_W)
ACC_W, 2*DATA_W+clog2(N_IN)+1, accumulator width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start_cfg  in  1  pulse: begin weight/bias load
start_inf  in  1  pulse: begin feature load and inference
in_valid  in  1  stream data valid
in_data  in  DATA_W  stream word (signed)
in_ready  out  1  stream accept; transfer when in_valid&&in_ready
busy  out  1  high in any state except IDLE/DONE
cfg_loaded  out  1  weights+biases complete
result_valid  out  1  max_idx/max_score/max_onehot valid
max_idx  out  clog2(N_OUT)  winning class
max_onehot  out  N_OUT  bit k set iff max_idx==k
max_score  out  DATA_W  winning score
err_nocfg  out  1  one-cycle pulse: start_inf rejected, no config

Behaviour:
- Reset (async, reset==0): state=IDLE; all outputs 0; cfg_loaded=0; counters 0. Weight/bias/feature arrays are not reset; contents are don't-care until reloaded.
- States: IDLE, LOAD_W, LOAD_B, LOAD_X, COMPUTE, DONE.
- IDLE/DONE, start_cfg: go to LOAD_W; clear cfg_loaded and result_valid.
- IDLE/DONE, start_inf with cfg_loaded=1: go to LOAD_X; clear result_valid. With cfg_loaded=0: stay; pulse err_nocfg.
- start_cfg and start_inf in the same cycle: start_cfg wins; no err_nocfg.
- Starts are ignored while busy.
- in_ready=1 only in LOAD_W/LOAD_B/LOAD_X. Stalls (in_valid=0) are unlimited, and the state holds.
- LOAD_W: N_IN*N_OUT words, output-major order w[o][i], i fastest. After the last word, go to LOAD_B.
- LOAD_B: N_OUT words b[o]. After the last word, set cfg_loaded=1 and go to IDLE.
- LOAD_X: N_IN words x[i]. After the last word, go to COMPUTE.
- COMPUTE: one MAC per cycle, exactly N_IN*N_OUT cycles. o outer, i inner.
  - At i=0: acc = (sign-extended b[o] << FRAC_W) + w[o][0]*x[0].
  - Otherwise: acc += w[o][i]*x[i]. Products are full 2*DATA_W signed; acc is ACC_W signed and never overflows.
  - On the cycle with i=N_IN-1: score = (acc_final >>> FRAC_W), i.e. arithmetic shift with truncation toward -inf, reduced to DATA_W (see Optional Feature).
  - Argmax update: o==0 loads unconditionally; otherwise update only if score > max (strictly signed). Ties keep the lowest index.
- DONE is entered the cycle after the final MAC. result_valid=1 is held until the next accepted start. Latency is N_IN*N_OUT+1 cycles from the last feature handshake edge to result_valid rising.
- max_onehot is decoded combinationally from the registered max_idx, gated by result_valid (0 when result_valid=0).
- New inference reuses stored weights; no reload is required. Reconfiguration mid-inference is not possible, since starts are ignored while busy.
- Counters wrap exactly at their terminal counts; no off-by-one reads beyond the array bounds.

Optional Feature:
SATURATE_EN
- Defined: shifted score is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before argmax and output.
- Undefined: score is the low DATA_W bits of the shifted accumulator (two's-complement wrap).

Decomposition:
- Package nn_pkg:
  - clog2 function
  - state encoding constants (IDLE..DONE)
  - ACC_W derivation
  - saturate/wrap helper function
- One sub-module, dense_mac: registered signed multiply-accumulate with clear-and-load on i=0 and a combinational score_out with saturation. The FSM, arrays and argmax stay in the top.

Test Plan:
- N_IN=3,N_OUT=2,DATA_W=16,FRAC_W=8; w0=[0x0100,0,0], w1=[0,0x0100,0], b=[0,0], x=[0x0200,0x0300,0] -> max_idx=1, max_onehot=2'b10, max_score=0x0300, result_valid 7 cycles after last x.
- Same config, x=[0x0300,0x0300,0] (tie) -> max_idx=0, max_score=0x0300. Second inference without reload, x=[0,0x0100,0] -> max_idx=1, max_score=0x0100.
- Biases b=[0xFF00,0xFE00] (-1.0,-2.0), x=0 -> max_idx=0, max_score=0xFF00.
- All weights and x = 0x7FFF, b=0 -> score is 0x7FFF with SATURATE_EN; 0xFD00 without.
- start_inf after reset with no config -> err_nocfg one-cycle pulse, state IDLE, in_ready=0. start_cfg+start_inf simultaneous -> LOAD_W, no error.
- Random in_valid gaps during all loads -> identical result to the gap-free run. Assert reset during COMPUTE -> outputs 0 and cfg_loaded=0 immediately (asynchronous); start_inf then gives err_nocfg.
